// File: rtl/remote_load_resp_router.sv
// Routes remote load responses into per-channel writeback FIFOs.
// Each channel tracks occupancy and head age, and raises force on a stall or when full.
module remote_load_resp_router #(
    parameter int data_width_p      = 32,
    parameter int reg_addr_width_p  = 5,
    parameter int num_channels_p    = 2,
    parameter int els_p             = 4,
    parameter int force_threshold_p = 8,
    parameter int chan_width_lp     = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
    parameter int count_width_lp    = $clog2(els_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic                                     returned_v_i,
    input  logic [chan_width_lp-1:0]                 returned_chan_i,
    input  logic [reg_addr_width_p-1:0]              returned_reg_id_i,
    input  logic [data_width_p-1:0]                  returned_data_i,
    output logic                                     returned_yumi_o,
    output logic [num_channels_p-1:0]                resp_v_o,
    output logic [num_channels_p*reg_addr_width_p-1:0] resp_rd_o,
    output logic [num_channels_p*data_width_p-1:0]   resp_data_o,
    output logic [num_channels_p-1:0]                resp_force_o,
    input  logic [num_channels_p-1:0]                resp_yumi_i,
    output logic [num_channels_p*count_width_lp-1:0] count_o,
    output logic                                     invalid_chan_o
);
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int age_width_lp   = $clog2(force_threshold_p + 1);
    localparam int entry_width_lp = reg_addr_width_p + data_width_p;

    localparam logic [chan_width_lp:0]    num_chan_lp = (chan_width_lp + 1)'(num_channels_p);
    localparam logic [count_width_lp-1:0] els_lp      = count_width_lp'(els_p);
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [age_width_lp-1:0]   thresh_lp   = age_width_lp'(force_threshold_p);

    logic                      chan_valid;
    logic                      sel_full;
    logic                      accept;
    logic [num_channels_p-1:0] full;
    logic [num_channels_p-1:0] enq;
    logic [num_channels_p-1:0] deq;
    logic [num_channels_p-1:0] v;

    assign chan_valid = {1'b0, returned_chan_i} < num_chan_lp;

    always_comb begin
        sel_full = 1'b0;
        for (int c = 0; c < num_channels_p; c++) begin
            if (returned_chan_i == chan_width_lp'(c)) sel_full = full[c];
        end
    end

    // A full channel refuses even if it drains this cycle: no bypass.
    assign accept          = reset_n_i & returned_v_i & (~chan_valid | ~sel_full);
    assign returned_yumi_o = accept;
    assign resp_v_o        = v;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) invalid_chan_o <= 1'b0;
        else            invalid_chan_o <= accept & ~chan_valid;
    end

    for (genvar c = 0; c < num_channels_p; c++) begin : ch
        logic [entry_width_lp-1:0] mem [els_p];
        logic [ptr_width_lp-1:0]   rptr;
        logic [ptr_width_lp-1:0]   wptr;
        logic [count_width_lp-1:0] count;
        logic [age_width_lp-1:0]   age;

        assign v[c]    = count != '0;
        assign full[c] = count == els_lp;
        assign enq[c]  = accept & chan_valid & (returned_chan_i == chan_width_lp'(c));
        assign deq[c]  = resp_yumi_i[c] & v[c];

        always_ff @(posedge clk_i) begin
            if (enq[c]) mem[wptr] <= {returned_reg_id_i, returned_data_i};
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
                age   <= '0;
            end else begin
                if (enq[c])
                    wptr <= (wptr == last_ptr_lp) ? '0 : wptr + ptr_width_lp'(1);
                if (deq[c])
                    rptr <= (rptr == last_ptr_lp) ? '0 : rptr + ptr_width_lp'(1);
                if (enq[c] & ~deq[c])
                    count <= count + count_width_lp'(1);
                else if (deq[c] & ~enq[c])
                    count <= count - count_width_lp'(1);
                // Age measures how long the current head has waited.
                if (!v[c] || deq[c])
                    age <= '0;
                else if (age != thresh_lp)
                    age <= age + age_width_lp'(1);
            end
        end

        assign {resp_rd_o[c*reg_addr_width_p +: reg_addr_width_p],
                resp_data_o[c*data_width_p +: data_width_p]} = mem[rptr];
        assign count_o[c*count_width_lp +: count_width_lp] = count;
        assign resp_force_o[c] = v[c] & ((age == thresh_lp) | full[c]);
    end

    yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        (resp_yumi_i & ~resp_v_o) == '0
    );

endmodule

// File: tb/tb_remote_load_resp_router.sv
// Scoreboard bench for remote_load_resp_router: queue model per channel,
// negedge monitor compares every DUT output against the model.
module tb_remote_load_resp_router;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int NC   = 3;
    localparam int ELS  = 3;
    localparam int THR  = 8;
    localparam int CHW  = 2;
    localparam int CNTW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic ret_v;
    logic [CHW-1:0] ret_chan;
    logic [RW-1:0] ret_rd;
    logic [DW-1:0] ret_data;
    logic ret_yumi;
    logic [NC-1:0] resp_v;
    logic [NC-1:0] resp_force;
    logic [NC-1:0] resp_yumi;
    logic [NC*RW-1:0] resp_rd;
    logic [NC*DW-1:0] resp_data;
    logic [NC*CNTW-1:0] count;
    logic inv;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    remote_load_resp_router #(
        .data_width_p(DW),
        .reg_addr_width_p(RW),
        .num_channels_p(NC),
        .els_p(ELS),
        .force_threshold_p(THR)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .returned_v_i(ret_v),
        .returned_chan_i(ret_chan),
        .returned_reg_id_i(ret_rd),
        .returned_data_i(ret_data),
        .returned_yumi_o(ret_yumi),
        .resp_v_o(resp_v),
        .resp_rd_o(resp_rd),
        .resp_data_o(resp_data),
        .resp_force_o(resp_force),
        .resp_yumi_i(resp_yumi),
        .count_o(count),
        .invalid_chan_o(inv)
    );

    typedef logic [RW+DW-1:0] ent_t;
    ent_t mq[NC][$];
    int age_m[NC];
    bit inv_m;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endfunction

    function automatic bit exp_accept();
        if (rst_n !== 1'b1 || ret_v !== 1'b1) return 1'b0;
        if (int'(ret_chan) >= NC) return 1'b1;
        return mq[int'(ret_chan)].size() < ELS;
    endfunction

    // Reference model: queues advance on each clock edge.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            bit acc;
            int chn;
            acc = exp_accept();
            chn = int'(ret_chan);
            for (int c = 0; c < NC; c++) begin
                bit dq;
                dq = resp_yumi[c] && mq[c].size() != 0;
                if (mq[c].size() == 0 || dq) age_m[c] = 0;
                else if (age_m[c] < THR) age_m[c]++;
                if (dq) void'(mq[c].pop_front());
            end
            if (acc && chn < NC) mq[chn].push_back({ret_rd, ret_data});
            inv_m = acc && chn >= NC;
        end else begin
            inv_m = 1'b0;
        end
    end

    always @(negedge rst_n) begin
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            age_m[c] = 0;
        end
        inv_m = 1'b0;
    end

    always @(negedge clk) begin
        check("returned_yumi", ret_yumi, exp_accept());
        check("invalid_chan", inv, inv_m);
        for (int c = 0; c < NC; c++) begin
            int n;
            n = mq[c].size();
            check($sformatf("v[%0d]", c), resp_v[c], n != 0);
            check($sformatf("count[%0d]", c), count[c*CNTW +: CNTW], n);
            check($sformatf("force[%0d]", c), resp_force[c],
                  n != 0 && (age_m[c] == THR || n == ELS));
            if (n != 0 && resp_v[c] === 1'b1)
                check($sformatf("head[%0d]", c),
                      {resp_rd[c*RW +: RW], resp_data[c*DW +: DW]}, mq[c][0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (resp_v != '0 && k < 20) begin
            resp_yumi = resp_v;
            step();
            k++;
        end
        resp_yumi = '0;
        check("drain", resp_v, '0);
    endtask

    initial begin
        rst_n = 1'b1;
        ret_v = 1'b0;
        ret_chan = '0;
        ret_rd = '0;
        ret_data = '0;
        resp_yumi = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // single entry on channel 1
        ret_v = 1'b1;
        ret_chan = 2'd1;
        ret_rd = 5'd7;
        ret_data = 32'hDEADBEEF;
        #1 check("t1_accept", ret_yumi, 1);
        step();
        ret_v = 1'b0;
        #1;
        check("t1_v", resp_v, 3'b010);
        check("t1_rd", resp_rd[RW +: RW], 7);
        check("t1_data", resp_data[DW +: DW], 32'hDEADBEEF);
        check("t1_count", count[CNTW +: CNTW], 1);
        check("t1_force", resp_force, 0);
        resp_yumi = 3'b010;
        step();
        resp_yumi = '0;

        // fill channel 0 past capacity
        for (int i = 0; i <= ELS; i++) begin
            ret_v = 1'b1;
            ret_chan = 2'd0;
            ret_rd = RW'(i);
            ret_data = $urandom;
            #1 check($sformatf("bp_accept%0d", i), ret_yumi, i < ELS);
            step();
        end
        check("bp_count", count[0 +: CNTW], ELS);
        check("bp_force", resp_force[0], 1);
        check("bp_reject", ret_yumi, 0);
        resp_yumi = 3'b001;
        #1 check("bp_no_bypass", ret_yumi, 0);
        step();
        resp_yumi = '0;
        #1 check("bp_retry", ret_yumi, 1);
        step();
        ret_v = 1'b0;
        drain();

        // force timeout on channel 2
        ret_v = 1'b1;
        ret_chan = 2'd2;
        ret_data = $urandom;
        step();
        ret_v = 1'b0;
        for (int k = 0; k <= THR + 2; k++) begin
            check($sformatf("age_force%0d", k), resp_force[2], k >= THR);
            step();
        end
        resp_yumi = 3'b100;
        step();
        resp_yumi = '0;
        check("age_cleared_force", resp_force[2], 0);
        check("age_cleared_v", resp_v[2], 0);

        // invalid channel is swallowed
        ret_v = 1'b1;
        ret_chan = 2'd3;
        #1 check("inv_accept", ret_yumi, 1);
        step();
        ret_v = 1'b0;
        check("inv_pulse", inv, 1);
        check("inv_counts", count, 0);
        step();
        check("inv_single", inv, 0);

        // random traffic with wrap-around
        repeat (1000) begin
            ret_v = 1'($urandom_range(0, 1));
            ret_chan = CHW'($urandom_range(0, 3));
            ret_rd = RW'($urandom);
            ret_data = $urandom;
            resp_yumi = NC'($urandom) & resp_v;
            step();
        end
        ret_v = 1'b0;
        resp_yumi = '0;
        drain();

        // asynchronous reset with entries buffered
        for (int i = 0; i < 2 * NC; i++) begin
            ret_v = 1'b1;
            ret_chan = CHW'(i % NC);
            ret_rd = RW'($urandom);
            ret_data = $urandom;
            step();
        end
        ret_v = 1'b0;
        check("pre_rst_count", count, {2'd2, 2'd2, 2'd2});
        #1 rst_n = 1'b0;
        #1;
        check("arst_v", resp_v, 0);
        check("arst_count", count, 0);
        check("arst_force", resp_force, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_v", resp_v, 0);
        check("post_rst_count", count, 0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/remote_load_resp_router.md
Name: remote_load_resp_router

Overview:
- N-channel writeback router for remote load responses. Sits between the endpoint's returned-packet port and the core's register-file writeback ports.
- Generalises the fixed int/float response split to num_channels_p channels.
- Each channel has its own buffer, an occupancy count, and an age-based force request.
- Responses addressed to a nonexistent channel are dropped and flagged.

Parameters:
- data_width_p, 32, response data width
- reg_addr_width_p, 5, destination register id width
- num_channels_p, 2, number of writeback channels (>=1)
- els_p, 4, per-channel FIFO depth (>=2)
- force_threshold_p, 8, stall cycles before a head entry requests force (>=1)
- chan_width_lp, `BSG_SAFE_CLOG2(num_channels_p), channel select width
- count_width_lp, `BSG_WIDTH(els_p), occupancy count width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- returned_v_i  in  1  returned response valid
- returned_chan_i  in  chan_width_lp  target channel
- returned_reg_id_i  in  reg_addr_width_p  destination register
- returned_data_i  in  data_width_p  load data
- returned_yumi_o  out  1  response consumed this cycle
- resp_v_o  out  num_channels_p  per-channel head valid
- resp_rd_o  out  num_channels_p*reg_addr_width_p  per-channel head register id
- resp_data_o  out  num_channels_p*data_width_p  per-channel head data
- resp_force_o  out  num_channels_p  per-channel force-writeback request
- resp_yumi_i  in  num_channels_p  per-channel head consumed
- count_o  out  num_channels_p*count_width_lp  per-channel occupancy
- invalid_chan_o  out  1  one-cycle pulse when a response is dropped

Behaviour:
- Reset: while reset_n_i is low, every FIFO is emptied and every age counter is cleared. Outputs during and after reset: resp_v_o=0, resp_force_o=0, count_o=0, invalid_chan_o=0, returned_yumi_o=0.
- A reset assertion in mid-operation discards all buffered entries immediately, asynchronously.
- Accept rule (combinational): returned_yumi_o = returned_v_i & (chan invalid | ~full[chan]).
  - Full means count == els_p.
  - No enqueue into a full FIFO, even when the same channel dequeues in the same cycle; this is the no-bypass rule.
- Channel valid means returned_chan_i < num_channels_p.
  - Valid channel: the accepted entry {reg_id, data} is written at the clock edge.
  - Invalid channel: the response is accepted, not stored, and invalid_chan_o is registered high for exactly the next cycle.
- Latency: an entry accepted at edge t is visible on resp_v_o/resp_rd_o/resp_data_o after edge t. No combinational path from returned_* to resp_*.
- Dequeue: resp_yumi_i[c] is legal only when resp_v_o[c]=1. Yumi with v=0 is ignored and is flagged by a simulation assertion.
- Head ordering: FIFO order is kept per channel. Across channels there is no ordering.
- Occupancy count_o[c]:
  - +1 on enqueue only, -1 on dequeue only, unchanged on both.
  - It never exceeds els_p and never goes below 0.
- Age counter per channel, width `BSG_WIDTH(force_threshold_p):
  - Clears when the FIFO is empty or when the head is dequeued.
  - Otherwise increments every cycle that resp_v_o[c]=1 and resp_yumi_i[c]=0, saturating at force_threshold_p.
- resp_force_o[c] = resp_v_o[c] & ((age[c] == force_threshold_p) | full[c]). It is registered-state derived and is not a function of resp_yumi_i.
- Wrap-around: read and write pointers are mod els_p. Non-power-of-two els_p is supported. The pointer wrap cannot corrupt count_o.
- Simultaneous events:
  - Enqueue to channel a and dequeue from channel b!=a are independent.
  - Enqueue and dequeue on the same non-full channel in one cycle leaves the count unchanged, and the age counter resets for the new head.

Test Plan:
- Reset and single entry: hold reset_n_i=0 for 3 cycles, then enqueue chan=1, rd=7, data=0xDEADBEEF. Required: yumi the same cycle; resp_v_o=2'b10 the next cycle with rd=7 and data=0xDEADBEEF; count_o[1]=1; no force.
- Full-channel back-pressure: els_p=4, enqueue 5 responses to chan 0 with no dequeue. Required: the first 4 are accepted; returned_yumi_o=0 for the 5th; count_o[0]=4; resp_force_o[0]=1. Dequeue once, then the 5th is accepted the following cycle.
- Force timeout: one entry on chan 0, resp_yumi_i held at 0. Required: resp_force_o[0] rises exactly 8 cycles after resp_v_o[0] rises (threshold 8) and stays high. After yumi, force=0 and the age counter is cleared.
- Invalid channel: num_channels_p=3, send chan=3. Required: yumi=1, no count changes, invalid_chan_o is high for one cycle only.
- Wrap and concurrency: els_p=3, random enqueue to chan 0/1 with random yumi for 1000 cycles against a reference model. Required: per-channel FIFO order matches the model, counts match, and there are no data mismatches across pointer wraps.
- Mid-operation reset: with 2 entries in each channel, pulse reset_n_i low asynchronously between edges. Required: resp_v_o=0 and count_o=0 immediately, and no stale entries appear after release.
